// File: rtl/sram_1rw_wmask_clr_if.sv
// rtl/sram_1rw_wmask_clr_if.sv - request/response bundle for the single-port SRAM model
interface sram_1rw_wmask_clr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WMASKS = 2
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout_valid0;
    logic                  busy0;

    modport master (
        output csb0, web0, wmask0, addr0, din0,
        input  dout0, dout_valid0, busy0
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0,
        output dout0, dout_valid0, busy0
    );
endinterface

// File: rtl/sram_1rw_wmask_clr.sv
// rtl/sram_1rw_wmask_clr.sv - single-port SRAM with write mask, registered read and post-reset clear
module sram_1rw_wmask_clr #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    WRITE_SIZE  = 4,
    parameter int                    NUM_WMASKS  = DATA_WIDTH / WRITE_SIZE,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                 clk0,
    input  logic                 rst0,
    sram_1rw_wmask_clr_if.slave  bus
);
    localparam int                    RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    // A word must split evenly into mask segments; refuse to elaborate otherwise.
    if ((DATA_WIDTH % WRITE_SIZE) != 0) begin : g_bad_write_size
        $error("DATA_WIDTH must be a multiple of WRITE_SIZE");
    end
    if (NUM_WMASKS != DATA_WIDTH / WRITE_SIZE) begin : g_bad_num_wmasks
        $error("NUM_WMASKS must equal DATA_WIDTH / WRITE_SIZE");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] clr_cnt_next;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  clr_we;
    logic                  req_ok;
    logic                  wr_en;
    logic                  rd_en;

    logic                  rd_pend;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;

    // Clear sequencer state and word counter; reset restarts the sweep from word 0.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Sweep one word per cycle; the counter parks on the last word so there is never a second pass.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_next = ST_IDLE;
                end else begin
                    clr_cnt_next = clr_cnt + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    // Requests only count in IDLE; anything presented while clearing is dropped.
    always_comb begin
        clr_we = (state == ST_CLEAR) && !rst0;
        req_ok = (state == ST_IDLE) && !rst0 && !bus.csb0;
        wr_en  = req_ok && !bus.web0;
        rd_en  = req_ok && bus.web0;
    end

    // Storage: the clear sweep owns the array until IDLE; user writes honour the per-segment mask.
    always_ff @(posedge clk0) begin
        if (clr_we) begin
            mem[clr_cnt] <= CLEAR_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) begin
                    mem[bus.addr0][i*WRITE_SIZE +: WRITE_SIZE] <= bus.din0[i*WRITE_SIZE +: WRITE_SIZE];
                end
            end
        end
    end

    // Read pipeline: capture the request, then fetch the word on the following edge so earlier writes are visible.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            rd_pend      <= 1'b0;
            rd_addr      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rd_pend      <= rd_en;
            dout_valid_q <= rd_pend;
            if (rd_en) begin
                rd_addr <= bus.addr0;
            end
            if (rd_pend) begin
                dout_q <= mem[rd_addr];
            end
        end
    end

    assign bus.dout0       = dout_q;
    assign bus.dout_valid0 = dout_valid_q;
    assign bus.busy0       = (state == ST_CLEAR);

endmodule

// File: tb/tb_sram_1rw_wmask_clr.sv
// tb/tb_sram_1rw_wmask_clr.sv - table and scoreboard bench for sram_1rw_wmask_clr
module tb_sram_1rw_wmask_clr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_1rw_wmask_clr_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_WMASKS(2)) bus_if ();

    sram_1rw_wmask_clr #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .WRITE_SIZE (4),
        .NUM_WMASKS (2),
        .CLEAR_VALUE(8'h00)
    ) dut (
        .clk0(clk),
        .rst0(rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    typedef struct {
        bit         is_wr;
        logic [3:0] addr;
        logic [7:0] din;
        logic [1:0] wmask;
        logic [7:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: a valid pulse must appear exactly on the due cycle of the oldest read, and never otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].due == cyc) begin
                chk("read_valid", bus_if.dout_valid0, 1);
                chk("read_data", bus_if.dout0, sb[0].data);
                void'(sb.pop_front());
            end else begin
                chk("no_valid", bus_if.dout_valid0, 0);
            end
        end
    end

    task automatic drive(input logic csb, input logic web, input logic [1:0] m,
                         input logic [3:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus_if.csb0   = csb;
        bus_if.web0   = web;
        bus_if.wmask0 = m;
        bus_if.addr0  = a;
        bus_if.din0   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 2'b00, 4'h0, 8'h00);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [1:0] m);
        drive(1'b0, 1'b0, m, a, d);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e);
        drive(1'b0, 1'b1, 2'b00, a, 8'h00);
        sb.push_back('{data: e, due: cyc + 2});
    endtask

    task automatic rd_dropped(input logic [3:0] a);
        drive(1'b0, 1'b1, 2'b00, a, 8'h00);
    endtask

    task automatic reset_and_clear(input int n, input bit check_busy);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus_if.csb0 = 1'b1;
        bus_if.web0 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_dout", bus_if.dout0, 8'h00);
        chk("reset_busy", bus_if.busy0, 1);
        if (check_busy) begin
            for (int i = 1; i < 16; i++) begin
                @(negedge clk);
                chk("busy_during_clear", bus_if.busy0, 1);
            end
            @(negedge clk);
            chk("busy_after_clear", bus_if.busy0, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 4'd3,  8'hA5, 2'b11, 8'h00};
        vecs[1]  = '{1'b0, 4'd3,  8'h00, 2'b00, 8'hA5};
        vecs[2]  = '{1'b1, 4'd15, 8'h3C, 2'b11, 8'h00};
        vecs[3]  = '{1'b0, 4'd15, 8'h00, 2'b00, 8'h3C};
        vecs[4]  = '{1'b1, 4'd5,  8'hFF, 2'b11, 8'h00};
        vecs[5]  = '{1'b1, 4'd5,  8'h12, 2'b01, 8'h00};
        vecs[6]  = '{1'b0, 4'd5,  8'h00, 2'b00, 8'hF2};
        vecs[7]  = '{1'b1, 4'd5,  8'h34, 2'b10, 8'h00};
        vecs[8]  = '{1'b0, 4'd5,  8'h00, 2'b00, 8'h32};
        vecs[9]  = '{1'b1, 4'd5,  8'hAB, 2'b00, 8'h00};
        vecs[10] = '{1'b0, 4'd5,  8'h00, 2'b00, 8'h32};
        vecs[11] = '{1'b0, 4'd3,  8'h00, 2'b00, 8'hA5};
        vecs[12] = '{1'b0, 4'd5,  8'h00, 2'b00, 8'h32};
        vecs[13] = '{1'b0, 4'd3,  8'h00, 2'b00, 8'hA5};

        bus_if.csb0   = 1'b1;
        bus_if.web0   = 1'b1;
        bus_if.wmask0 = 2'b00;
        bus_if.addr0  = 4'h0;
        bus_if.din0   = 8'h00;

        // Reset, busy window, and every word cleared.
        reset_and_clear(2, 1'b1);
        for (int a = 0; a < 16; a++) rd(4'(a), 8'h00);
        idle(3);

        // Write/read, masked writes, back-to-back reads.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].din, vecs[i].wmask);
            else               rd(vecs[i].addr, vecs[i].exp);
        end
        idle(4);
        @(negedge clk);
        chk("dout_hold", bus_if.dout0, 8'hA5);

        // Requests while busy are dropped; words cleared before them must stay cleared.
        reset_and_clear(2, 1'b0);
        idle(2);
        wr(4'd0, 8'hFF, 2'b11);
        rd_dropped(4'd0);
        wr(4'd1, 8'hAA, 2'b11);
        rd_dropped(4'd1);
        idle(14);
        rd(4'd0, 8'h00);
        rd(4'd1, 8'h00);
        idle(3);

        // Reset with a read in flight, then a second reset midway through the clear.
        wr(4'd3, 8'h5A, 2'b11);
        rd_dropped(4'd3);
        reset_and_clear(2, 1'b0);
        idle(8);
        reset_and_clear(1, 1'b1);
        rd(4'd3, 8'h00);
        idle(4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
